sha256_block_packer: RTL and testbench
======================================

SHA256_BLOCK_PACKER -- requirements
Module: sha256_block_packer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 clear_i  input  1  synchronous active-high clear; returns the block to its reset state.
REQ-005 s_data_i  input  32  message word, big-endian (byte 0 in [31:24]).
REQ-006 s_valid_i  input  1  s_data_i valid.
REQ-007 s_last_i  input  1  current word is the last word of the message.
REQ-008 s_bytes_i  input  3  valid bytes in the last word (0..4), MSB-first; ignored when s_last_i=0.
REQ-009 s_ready_o  output  1  word accepted when s_valid_i && s_ready_o.
REQ-010 blk_data_o  output  512  packed block; word k occupies [511-32k -: 32].
REQ-011 blk_valid_o  output  1  block presented.
REQ-012 blk_end_o  output  1  presented block is the final block of the message.
REQ-013 blk_last_o  output  10  valid message bits in the final block (0..512); 512 when blk_end_o=0.
REQ-014 blk_ready_i  input  1  downstream hash core ready; block transferred when blk_valid_o && blk_ready_i.
REQ-015 digest_valid_i  input  1  downstream digest-valid level.

Function
REQ-016 States SHALL be FILL, HOLD and WAIT_DONE.
REQ-017 FILL: s_ready_o=1, blk_valid_o=0; each accepted word is written to slot wcnt (4-bit), and wcnt increments.
REQ-018 A non-last accepted word in slot 15 SHALL cause a transition to HOLD with blk_end_o=0 and blk_last_o=512; blk_valid_o is high the next cycle.
REQ-019 An accepted word with s_last_i=1 SHALL cause a transition to HOLD with blk_end_o=1 and blk_last_o=32*wcnt+8*min(s_bytes_i,4), where wcnt is the value before the increment.
REQ-020 s_bytes_i values 5..7 SHALL be treated as 4.
REQ-021 In the last word, bytes at and beyond s_bytes_i SHALL be zeroed; all slots not written SHALL read as zero.
REQ-022 s_last_i with s_bytes_i=0 in slot 0 SHALL produce an end block with blk_last_o=0 and blk_data_o=0 (empty message or exact-multiple tail).
REQ-023 HOLD: s_ready_o=0; blk_data_o, blk_end_o and blk_last_o SHALL be held stable until the transfer.
REQ-024 On transfer with blk_end_o=0, the block SHALL go to FILL, zero the buffer and clear wcnt in the same edge.
REQ-025 On transfer with blk_end_o=1, the block SHALL go to WAIT_DONE, zero the buffer and clear wcnt.
REQ-026 WAIT_DONE: s_ready_o=0, blk_valid_o=0; the block SHALL leave to FILL on the cycle after a rising edge of digest_valid_i, detected against a registered copy.
REQ-027 A digest_valid_i level that is already high on entry to WAIT_DONE SHALL NOT release it; a low-then-high sequence is required.
REQ-028 The block SHALL accept at most one word per cycle and hold no words beyond the single 512-bit buffer; there is no input-side skid.
REQ-029 blk_last_o SHALL be computed at 10-bit width with no wrap; its maximum value is 512.

Reset
REQ-030 On resetn low (asynchronous) or clear_i high (synchronous), the block SHALL assume: state=FILL, wcnt=0, buffer=0, digest_valid_i edge register=0, s_ready_o=1, blk_valid_o=0, blk_end_o=0, blk_last_o=0, blk_data_o=0.
REQ-031 clear_i SHALL take priority over every simultaneous event, including a transfer, an accepted word and a digest edge.
REQ-032 Reset or clear during HOLD or WAIT_DONE SHALL discard the pending block with no transfer.

Verification
REQ-033 Scenario "abc": one beat 0x61626364, last=1, bytes=3 -> blk_data_o[511:480]=0x61626300, rest 0, blk_end_o=1, blk_last_o=24.
REQ-034 Scenario full block: 16 beats 0x00000000..0x0000000F, none last -> one block, blk_end_o=0, blk_last_o=512, word k=k; s_ready_o=0 until transfer.
REQ-035 Scenario empty message: one beat, last=1, bytes=0 -> blk_data_o=0, blk_end_o=1, blk_last_o=0; then WAIT_DONE.
REQ-036 Scenario backpressure: blk_ready_i held low 10 cycles -> outputs stable, s_ready_o=0, no word lost; transfer on the first cycle blk_ready_i=1.
REQ-037 Scenario WAIT_DONE: digest_valid_i high on entry, then low 5 cycles, then high -> s_ready_o=1 exactly one cycle after the rise, not before.
REQ-038 Scenario clear: clear_i asserted in HOLD coincident with blk_ready_i=1 -> no transfer; next cycle all outputs at reset values, wcnt=0.

Source files
------------

// File: rtl/sha256_block_packer.sv
// Packs a big-endian 32-bit word stream into 512-bit blocks for a SHA-256 core,
// masking the tail word and reporting how many message bits the final block holds.
module sha256_block_packer (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clear_i,
   input  logic [31:0]  s_data_i,
   input  logic         s_valid_i,
   input  logic         s_last_i,
   input  logic [2:0]   s_bytes_i,
   output logic         s_ready_o,
   output logic [511:0] blk_data_o,
   output logic         blk_valid_o,
   output logic         blk_end_o,
   output logic [9:0]   blk_last_o,
   input  logic         blk_ready_i,
   input  logic         digest_valid_i
);

   localparam logic [1:0] FILL      = 2'd0;
   localparam logic [1:0] HOLD      = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;

   logic [1:0]  state;
   logic [3:0]  wcnt;
   logic [31:0] words [16];
   logic        end_r;
   logic [9:0]  last_r;
   logic        dv_q;
   logic [2:0]  nbytes;

   function automatic logic [2:0] sat_bytes(input logic [2:0] b);
      return (b > 3'd4) ? 3'd4 : b;
   endfunction

   // Keeps the first n bytes of a big-endian word, zeroing the rest.
   function automatic logic [31:0] byte_mask(input logic [2:0] n);
      logic [31:0] m;
      case (n)
         3'd0:    m = 32'h0000_0000;
         3'd1:    m = 32'hFF00_0000;
         3'd2:    m = 32'hFFFF_0000;
         3'd3:    m = 32'hFFFF_FF00;
         default: m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

   assign nbytes      = sat_bytes(s_bytes_i);
   assign s_ready_o   = (state == FILL);
   assign blk_valid_o = (state == HOLD);
   assign blk_end_o   = end_r;
   assign blk_last_o  = last_r;

   always_comb begin
      blk_data_o = '0;
      for (int k = 0; k < 16; k++) begin
         blk_data_o[511 - 32*k -: 32] = words[k];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= FILL;
         wcnt   <= '0;
         end_r  <= 1'b0;
         last_r <= '0;
         dv_q   <= 1'b0;
         for (int k = 0; k < 16; k++) words[k] <= '0;
      end else if (clear_i) begin
         state  <= FILL;
         wcnt   <= '0;
         end_r  <= 1'b0;
         last_r <= '0;
         dv_q   <= 1'b0;
         for (int k = 0; k < 16; k++) words[k] <= '0;
      end else begin
         dv_q <= digest_valid_i;
         case (state)
            FILL: begin
               if (s_valid_i) begin
                  wcnt <= wcnt + 4'd1;
                  if (s_last_i) begin
                     words[wcnt] <= s_data_i & byte_mask(nbytes);
                     state       <= HOLD;
                     end_r       <= 1'b1;
                     last_r      <= {1'b0, wcnt, 5'b0} + {5'b0, nbytes, 2'b0} + {5'b0, nbytes, 2'b0};
                  end else begin
                     words[wcnt] <= s_data_i;
                     if (wcnt == 4'd15) begin
                        state  <= HOLD;
                        end_r  <= 1'b0;
                        last_r <= 10'd512;
                     end
                  end
               end
            end
            HOLD: begin
               if (blk_ready_i) begin
                  state  <= end_r ? WAIT_DONE : FILL;
                  wcnt   <= '0;
                  end_r  <= 1'b0;
                  last_r <= '0;
                  for (int k = 0; k < 16; k++) words[k] <= '0;
               end
            end
            WAIT_DONE: begin
               // Only a fresh low-to-high digest edge releases the packer.
               if (digest_valid_i && !dv_q) state <= FILL;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_block_packer.sv
// Directed self-checking bench for sha256_block_packer.
module tb_sha256_block_packer;

   logic         clk = 1'b0;
   logic         resetn, clear_i;
   logic [31:0]  s_data_i;
   logic         s_valid_i, s_last_i;
   logic [2:0]   s_bytes_i;
   logic         s_ready_o;
   logic [511:0] blk_data_o;
   logic         blk_valid_o, blk_end_o;
   logic [9:0]   blk_last_o;
   logic         blk_ready_i, digest_valid_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sha256_block_packer dut (
      .clk(clk), .resetn(resetn), .clear_i(clear_i),
      .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_bytes_i(s_bytes_i),
      .s_ready_o(s_ready_o), .blk_data_o(blk_data_o), .blk_valid_o(blk_valid_o),
      .blk_end_o(blk_end_o), .blk_last_o(blk_last_o), .blk_ready_i(blk_ready_i),
      .digest_valid_i(digest_valid_i)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
      s_data_i = d; s_valid_i = 1'b1; s_last_i = last; s_bytes_i = nb;
      cyc();
      s_valid_i = 1'b0; s_last_i = 1'b0; s_bytes_i = 3'd0;
   endtask

   // Transfers the held end block and pulses digest_valid_i to return to FILL.
   task automatic finish_block();
      blk_ready_i = 1'b1; cyc(); blk_ready_i = 1'b0;
      digest_valid_i = 1'b1; cyc(); digest_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; #2;
      n_checks++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", s_ready_o); end
      n_checks++; if (blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", blk_valid_o); end
      n_checks++; if (blk_end_o !== 1'b0) begin n_fail++; $display("FAIL reset_end: got %b expected 0", blk_end_o); end
      n_checks++; if (blk_last_o !== 10'd0) begin n_fail++; $display("FAIL reset_last: got %0d expected 0", blk_last_o); end
      n_checks++; if (blk_data_o !== 512'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", blk_data_o); end
      cyc(); cyc();
      resetn = 1'b1;
      cyc();
   endtask

   task automatic test_abc();
      logic [511:0] exp;
      exp = '0; exp[511 -: 32] = 32'h6162_6300;
      drive_word(32'h6162_6364, 1'b1, 3'd3);
      @(negedge clk);
      n_checks++; if (blk_valid_o !== 1'b1) begin n_fail++; $display("FAIL abc_valid: got %b expected 1", blk_valid_o); end
      n_checks++; if (blk_data_o !== exp) begin n_fail++; $display("FAIL abc_data: got %h expected %h", blk_data_o, exp); end
      n_checks++; if (blk_end_o !== 1'b1) begin n_fail++; $display("FAIL abc_end: got %b expected 1", blk_end_o); end
      n_checks++; if (blk_last_o !== 10'd24) begin n_fail++; $display("FAIL abc_last: got %0d expected 24", blk_last_o); end
      n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL abc_ready_hold: got %b expected 0", s_ready_o); end
      blk_ready_i = 1'b1; cyc(); blk_ready_i = 1'b0;
      @(negedge clk);
      n_checks++; if (blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL abc_wait_valid: got %b expected 0", blk_valid_o); end
      n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL abc_wait_ready: got %b expected 0", s_ready_o); end
      n_checks++; if (blk_data_o !== 512'd0) begin n_fail++; $display("FAIL abc_wait_data: got %h expected 0", blk_data_o); end
      digest_valid_i = 1'b1; cyc(); digest_valid_i = 1'b0;
      @(negedge clk);
      n_checks++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL abc_release: got %b expected 1", s_ready_o); end
      cyc();
   endtask

   task automatic test_full_block_backpressure();
      logic [511:0] exp;
      exp = '0;
      for (int k = 0; k < 16; k++) exp[511 - 32*k -: 32] = 32'(k);
      for (int k = 0; k < 16; k++) begin
         drive_word(32'(k), 1'b0, 3'd0);
         if (k < 15) begin
            @(negedge clk);
            n_checks++; if (s_ready_o !== 1'b1 || blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_fill_%0d: ready %b valid %b expected 1 0", k, s_ready_o, blk_valid_o); end
            #4;
         end
      end
      // Stall the sink for 10 cycles while the source keeps offering a word.
      s_data_i = 32'hCAFE_F00D; s_valid_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++; if (blk_valid_o !== 1'b1 || s_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ctrl_%0d: valid %b ready %b expected 1 0", c, blk_valid_o, s_ready_o); end
         n_checks++; if (blk_data_o !== exp) begin n_fail++; $display("FAIL bp_data_%0d: got %h expected %h", c, blk_data_o, exp); end
         n_checks++; if (blk_end_o !== 1'b0 || blk_last_o !== 10'd512) begin n_fail++; $display("FAIL bp_meta_%0d: end %b last %0d expected 0 512", c, blk_end_o, blk_last_o); end
         cyc();
      end
      s_valid_i = 1'b0;
      blk_ready_i = 1'b1;
      @(negedge clk);
      n_checks++; if (blk_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_xfer_valid: got %b expected 1", blk_valid_o); end
      @(posedge clk); #1; blk_ready_i = 1'b0;
      @(negedge clk);
      n_checks++; if (s_ready_o !== 1'b1 || blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_after: ready %b valid %b expected 1 0", s_ready_o, blk_valid_o); end
      n_checks++; if (blk_data_o !== 512'd0) begin n_fail++; $display("FAIL bp_after_data: got %h expected 0", blk_data_o); end
      n_checks++; if (blk_last_o !== 10'd0) begin n_fail++; $display("FAIL bp_after_last: got %0d expected 0", blk_last_o); end
      cyc();
   endtask

   task automatic test_partial_sat();
      logic [511:0] exp;
      exp = '0;
      exp[511 -: 32] = 32'h1122_3344; exp[479 -: 32] = 32'h5566_7788; exp[447 -: 32] = 32'h99AA_BBCC;
      drive_word(32'h1122_3344, 1'b0, 3'd0);
      drive_word(32'h5566_7788, 1'b0, 3'd5);
      drive_word(32'h99AA_BBCC, 1'b1, 3'd7);
      @(negedge clk);
      n_checks++; if (blk_last_o !== 10'd96) begin n_fail++; $display("FAIL sat_last: got %0d expected 96", blk_last_o); end
      n_checks++; if (blk_data_o !== exp) begin n_fail++; $display("FAIL sat_data: got %h expected %h", blk_data_o, exp); end
      n_checks++; if (blk_end_o !== 1'b1) begin n_fail++; $display("FAIL sat_end: got %b expected 1", blk_end_o); end
      #4; finish_block();
      exp = '0; exp[511 -: 32] = 32'hA1B2_C3D4; exp[479 -: 32] = 32'hE500_0000;
      drive_word(32'hA1B2_C3D4, 1'b0, 3'd0);
      drive_word(32'hE5F6_0718, 1'b1, 3'd1);
      @(negedge clk);
      n_checks++; if (blk_last_o !== 10'd40) begin n_fail++; $display("FAIL one_byte_last: got %0d expected 40", blk_last_o); end
      n_checks++; if (blk_data_o !== exp) begin n_fail++; $display("FAIL one_byte_data: got %h expected %h", blk_data_o, exp); end
      #4; finish_block();
      // Last word landing in slot 15 with all four bytes reaches the 512 ceiling.
      for (int k = 0; k < 15; k++) drive_word(32'hFFFF_FFFF, 1'b0, 3'd0);
      drive_word(32'h0102_0304, 1'b1, 3'd4);
      @(negedge clk);
      n_checks++; if (blk_last_o !== 10'd512 || blk_end_o !== 1'b1) begin n_fail++; $display("FAIL max_last: last %0d end %b expected 512 1", blk_last_o, blk_end_o); end
      n_checks++; if (blk_data_o[31:0] !== 32'h0102_0304) begin n_fail++; $display("FAIL max_tail: got %h expected 01020304", blk_data_o[31:0]); end
      #4; finish_block();
   endtask

   task automatic test_empty_wait_done();
      digest_valid_i = 1'b1;
      drive_word(32'hDEAD_BEEF, 1'b1, 3'd0);
      @(negedge clk);
      n_checks++; if (blk_data_o !== 512'd0) begin n_fail++; $display("FAIL empty_data: got %h expected 0", blk_data_o); end
      n_checks++; if (blk_end_o !== 1'b1 || blk_last_o !== 10'd0) begin n_fail++; $display("FAIL empty_meta: end %b last %0d expected 1 0", blk_end_o, blk_last_o); end
      #4; blk_ready_i = 1'b1; cyc(); blk_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL wait_high_%0d: ready %b expected 0", c, s_ready_o); end
         cyc();
      end
      digest_valid_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++; if (s_ready_o !== 1'b0 || blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL wait_low_%0d: ready %b valid %b expected 0 0", c, s_ready_o, blk_valid_o); end
         cyc();
      end
      digest_valid_i = 1'b1;
      @(negedge clk);
      n_checks++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL wait_early: ready %b expected 0", s_ready_o); end
      cyc();
      @(negedge clk);
      n_checks++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL wait_release: ready %b expected 1", s_ready_o); end
      #4; digest_valid_i = 1'b0;
   endtask

   task automatic test_clear();
      logic [511:0] exp;
      drive_word(32'h0000_0001, 1'b0, 3'd0);
      drive_word(32'h0000_0002, 1'b1, 3'd4);
      s_data_i = 32'h7777_7777; s_valid_i = 1'b1;
      blk_ready_i = 1'b1; clear_i = 1'b1; digest_valid_i = 1'b1;
      cyc();
      blk_ready_i = 1'b0; clear_i = 1'b0; s_valid_i = 1'b0; digest_valid_i = 1'b0;
      @(negedge clk);
      n_checks++; if (s_ready_o !== 1'b1 || blk_valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_ctrl: ready %b valid %b expected 1 0", s_ready_o, blk_valid_o); end
      n_checks++; if (blk_end_o !== 1'b0 || blk_last_o !== 10'd0) begin n_fail++; $display("FAIL clr_meta: end %b last %0d expected 0 0", blk_end_o, blk_last_o); end
      n_checks++; if (blk_data_o !== 512'd0) begin n_fail++; $display("FAIL clr_data: got %h expected 0", blk_data_o); end
      #4;
      exp = '0; exp[511 -: 32] = 32'hAABB_CCDD;
      drive_word(32'hAABB_CCDD, 1'b1, 3'd4);
      @(negedge clk);
      n_checks++; if (blk_last_o !== 10'd32) begin n_fail++; $display("FAIL clr_wcnt: last %0d expected 32", blk_last_o); end
      n_checks++; if (blk_data_o !== exp) begin n_fail++; $display("FAIL clr_next_data: got %h expected %h", blk_data_o, exp); end
      #4; blk_ready_i = 1'b1; cyc(); blk_ready_i = 1'b0;
      clear_i = 1'b1; cyc(); clear_i = 1'b0;
      @(negedge clk);
      n_checks++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL clr_wait: ready %b expected 1", s_ready_o); end
      #4;
   endtask

   task automatic test_async_reset();
      drive_word(32'h1234_5678, 1'b1, 3'd2);
      #2; resetn = 1'b0; #1;
      n_checks++; if (blk_valid_o !== 1'b0 || s_ready_o !== 1'b1) begin n_fail++; $display("FAIL areset_ctrl: valid %b ready %b expected 0 1", blk_valid_o, s_ready_o); end
      n_checks++; if (blk_data_o !== 512'd0 || blk_last_o !== 10'd0) begin n_fail++; $display("FAIL areset_data: last %0d data %h expected 0", blk_last_o, blk_data_o); end
      cyc(); resetn = 1'b1; cyc();
   endtask

   initial begin
      resetn = 1'b1; clear_i = 1'b0;
      s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0; s_bytes_i = '0;
      blk_ready_i = 1'b0; digest_valid_i = 1'b0;
      #2;
      test_reset();
      test_abc();
      test_full_block_backpressure();
      test_partial_sat();
      test_empty_wait_done();
      test_clear();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1);
   end

endmodule
